// File: rtl/regfile_2r1w_param.sv
// regfile_2r1w_param: parametrised 2-read/1-write register file with
// registered read ports, optional write-through bypass, optional hardwired
// zero register and a sequential clear engine that sweeps the array one
// entry per cycle after reset or on request.
//
// Handshake: there is no valid/ready pair. A write is accepted on any rising
// edge where we=1 and busy=0, and is dropped otherwise. Read data for the
// selects and write inputs seen at an edge appears on A/B after that edge.
module regfile_2r1w_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 16,
    parameter int                ZERO_REG = 0,
    parameter int                BYPASS   = 1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] replaceSel,
    input  logic [DATA_W-1:0] replaceData,
    input  logic [ADDR_W-1:0] A_sel,
    input  logic [ADDR_W-1:0] B_sel,
    input  logic              clear,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              state_dbg
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_fire;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    // Address lies inside the implemented array.
    function automatic logic in_range(input logic [ADDR_W-1:0] sel);
        return {1'b0, sel} < DEPTH_PTR;
    endfunction

    // Address is the hardwired zero register (only when that option is on).
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] sel);
        return (ZERO_REG != 0) && (sel == '0);
    endfunction

    // busy is a decode of the state register, so it is glitch-free and
    // has no combinational path from any input.
    assign busy      = (state == CLEAR);
    assign state_dbg = state;

    // A user write takes effect only when idle and aimed at a real register.
    assign wr_fire = (state == READY) && we && in_range(replaceSel)
                     && !is_zero_reg(replaceSel);

    // Next-state logic and the single array write port (sweep or user write).
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_waddr  = replaceSel;
        mem_wdata  = replaceData;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr[ADDR_W-1:0];
                mem_wdata = CLR_VAL;
                if (ptr == LAST_PTR) begin
                    state_next = READY;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            READY: begin
                mem_we = wr_fire;
                // A write in the same cycle still lands; the sweep then wipes it.
                if (clear) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Read-port data for the coming edge: zero while sweeping, out of range
    // or on the zero register; new data on a bypassed same-address write.
    always_comb begin
        a_next = '0;
        b_next = '0;
        if (state == READY) begin
            if (in_range(A_sel) && !is_zero_reg(A_sel)) begin
                if ((BYPASS != 0) && wr_fire && (A_sel == replaceSel))
                    a_next = replaceData;
                else
                    a_next = mem[A_sel];
            end
            if (in_range(B_sel) && !is_zero_reg(B_sel)) begin
                if ((BYPASS != 0) && wr_fire && (B_sel == replaceSel))
                    b_next = replaceData;
                else
                    b_next = mem[B_sel];
            end
        end
    end

    // State, sweep pointer and registered read ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            A     <= '0;
            B     <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            A     <= a_next;
            B     <= b_next;
        end
    end

    // Array storage; reset leaves contents alone, the sweep does the wiping.
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Testbench for regfile_2r1w_param. Two instances share one stimulus stream:
// u0 uses the default parameters, u1 uses DEPTH=12, ZERO_REG=1, BYPASS=0 and
// a nonzero clear value. A behavioural model tracks each instance as an
// array plus a count of remaining busy cycles.
module tb_regfile_2r1w_param;

    localparam int DW = 8;
    localparam int AW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst         = 1'b1;
    logic          we          = 1'b0;
    logic [AW-1:0] replaceSel  = '0;
    logic [DW-1:0] replaceData = '0;
    logic [AW-1:0] A_sel       = '0;
    logic [AW-1:0] B_sel       = '0;
    logic          clear       = 1'b0;

    logic [DW-1:0] a_o    [2];
    logic [DW-1:0] b_o    [2];
    logic          busy_o [2];
    logic          st_o   [2];

    regfile_2r1w_param u0 (
        .clk(clk), .rst(rst), .we(we), .replaceSel(replaceSel),
        .replaceData(replaceData), .A_sel(A_sel), .B_sel(B_sel), .clear(clear),
        .A(a_o[0]), .B(b_o[0]), .busy(busy_o[0]), .state_dbg(st_o[0])
    );

    regfile_2r1w_param #(
        .DEPTH(12), .ZERO_REG(1), .BYPASS(0), .CLR_VAL(8'h3C)
    ) u1 (
        .clk(clk), .rst(rst), .we(we), .replaceSel(replaceSel),
        .replaceData(replaceData), .A_sel(A_sel), .B_sel(B_sel), .clear(clear),
        .A(a_o[1]), .B(b_o[1]), .busy(busy_o[1]), .state_dbg(st_o[1])
    );

    // ---------------- reference model ----------------
    int            dep  [2] = '{16, 12};
    int            zr   [2] = '{0, 1};
    int            byp  [2] = '{1, 0};
    logic [DW-1:0] clrv [2] = '{8'h00, 8'h3C};

    logic [DW-1:0] mdl       [2][16];
    int            busy_left [2];
    logic [DW-1:0] exp_a     [2];
    logic [DW-1:0] exp_b     [2];

    int vectors    = 0;
    int miscompares = 0;

    function automatic logic write_ok(input int k, input logic [AW-1:0] sel);
        return (int'(sel) < dep[k]) && !(zr[k] != 0 && sel == '0);
    endfunction

    function automatic logic [DW-1:0] model_read(input int k, input logic [AW-1:0] sel);
        if (int'(sel) >= dep[k]) return '0;
        if (zr[k] != 0 && sel == '0) return '0;
        if (byp[k] != 0 && we && sel == replaceSel && write_ok(k, replaceSel))
            return replaceData;
        return mdl[k][sel];
    endfunction

    // A sweep is only observable once it completes, so the model wipes
    // the whole array at the moment a sweep begins.
    task automatic start_sweep(input int k);
        busy_left[k] = dep[k];
        for (int i = 0; i < 16; i++) mdl[k][i] = clrv[k];
    endtask

    // Advance the model by one edge using the inputs as they were before it.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_a[k] = '0;
                exp_b[k] = '0;
                start_sweep(k);
            end else if (busy_left[k] > 0) begin
                exp_a[k] = '0;
                exp_b[k] = '0;
                busy_left[k]--;
            end else begin
                exp_a[k] = model_read(k, A_sel);
                exp_b[k] = model_read(k, B_sel);
                if (we && write_ok(k, replaceSel)) mdl[k][replaceSel] = replaceData;
                if (clear) start_sweep(k);
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input int k,
                         input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s u%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("A", k, a_o[k], exp_a[k]);
            check("B", k, b_o[k], exp_b[k]);
            check("busy", k, {7'd0, busy_o[k]}, (busy_left[k] > 0) ? 8'd1 : 8'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        we = 1'b0; clear = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0; clear = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; replaceSel = a; replaceData = d;
        step();
        we = 1'b0;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        A_sel = a; B_sel = b;
        step();
    endtask

    task automatic random_cycle(input int clear_odds);
        we          = ($urandom_range(0, 1) == 1);
        replaceSel  = AW'($urandom_range(0, 15));
        replaceData = DW'($urandom_range(1, 255));
        A_sel       = AW'($urandom_range(0, 15));
        B_sel       = AW'($urandom_range(0, 15));
        clear       = (clear_odds > 0) && ($urandom_range(1, clear_odds) == 1);
        step();
        clear = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Reset, then the sweep: busy for exactly DEPTH cycles.
        do_reset();
        idle(17);
        for (int i = 0; i < 16; i++) read(AW'(i), AW'(15 - i));

        // Directed writes and a two-port read.
        write(4'd0, 8'hAA);
        write(4'd1, 8'hBB);
        write(4'd2, 8'hCC);
        write(4'd15, 8'hDD);
        write(4'd10, 8'hEE);
        read(4'd10, 4'd15);
        read(4'd0, 4'd1);
        read(4'd2, 4'd2);

        // Same-cycle write and read of one address (bypass vs old value).
        A_sel = 4'd3; B_sel = 4'd3;
        write(4'd3, 8'h5A);
        read(4'd3, 4'd4);

        // Zero register and out-of-range writes.
        write(4'd0, 8'hFF);
        read(4'd0, 4'd0);
        write(4'd13, 8'h77);
        read(4'd13, 4'd0);

        // Fill with random nonzero data, then clear with writes during busy.
        for (int i = 0; i < 40; i++) random_cycle(0);
        we = 1'b1; replaceSel = 4'd5; replaceData = 8'h99; clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 18; i++) begin
            we = 1'b1; replaceSel = AW'(i % 16); replaceData = 8'hA5;
            A_sel = AW'(i % 16); B_sel = AW'(15 - (i % 16));
            clear = (i == 3);
            step();
        end
        we = 1'b0; clear = 1'b0;
        for (int i = 0; i < 16; i++) read(AW'(i), AW'((i + 7) % 16));

        // Reset five cycles into a sweep restarts it.
        for (int i = 0; i < 10; i++) random_cycle(0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        idle(5);
        do_reset();
        idle(18);

        // Long random run with occasional clear requests.
        for (int i = 0; i < 300; i++) random_cycle(25);
        idle(18);
        for (int i = 0; i < 16; i++) read(AW'(i), AW'(i ^ 5));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
